wb_arbiter: RTL and testbench

Write-back arbiter between the execution units and the register file's single write port. It accepts result requests from three units: ALU-misc (requester 0), multiplier (requester 1) and load/store (requester 2). It grants one request per cycle with round-robin priority and drives a registered write-back stage (`wb_*`) into the register file and the bypass network. It also handles `x0` writes, pipeline flush and a saturating contention counter for performance analysis.

---
 rtl/wb_arbiter.sv | 106 ++++++++++
 tb/tb_wb_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin grant of one real result per cycle onto the
// register-file write port; x0 writes are absorbed without consuming the grant.
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [2:0]            req_valid,
    input  logic [3*REG_W-1:0]    req_reg,
    input  logic [3*DATA_W-1:0]   req_data,
    output logic [2:0]            req_ready,
    output logic                  wb_valid,
    output logic [REG_W-1:0]      wb_reg,
    output logic [DATA_W-1:0]     wb_data,
    output logic [1:0]            wb_src,
    output logic [CNT_W-1:0]      conflict_cnt
);

    logic [2:0]        is_real;
    logic [2:0]        is_null;
    logic              granted;
    logic [1:0]        win;
    logic [1:0]        scan_idx;
    logic              contended;

    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic              wb_valid_q, wb_valid_d;
    logic [REG_W-1:0]  wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [1:0]        wb_src_q, wb_src_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    for (genvar i = 0; i < 3; i++) begin : g_dec
        assign is_real[i] = req_valid[i] && (req_reg[i*REG_W +: REG_W] != '0);
        assign is_null[i] = req_valid[i] && (req_reg[i*REG_W +: REG_W] == '0);
    end

    // Scan starting at the pointer, wrapping 2 -> 0; first real request wins.
    always_comb begin
        granted  = 1'b0;
        win      = 2'd0;
        scan_idx = rr_ptr_q;
        for (int k = 0; k < 3; k++) begin
            if (!granted && is_real[scan_idx]) begin
                granted = 1'b1;
                win     = scan_idx;
            end
            scan_idx = (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            req_ready[i] = !flush && (is_null[i] || (granted && win == 2'(i)));
        end
    end

    assign contended = (is_real[0] && is_real[1]) || (is_real[0] && is_real[2]) ||
                       (is_real[1] && is_real[2]);

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wb_valid_d = granted && !flush;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;
        wb_src_d   = wb_src_q;
        cnt_d      = cnt_q;
        if (granted && !flush) begin
            rr_ptr_d  = (win == 2'd2) ? 2'd0 : win + 2'd1;
            wb_reg_d  = req_reg[win*REG_W +: REG_W];
            wb_data_d = req_data[win*DATA_W +: DATA_W];
            wb_src_d  = win;
        end
        if (!flush && contended && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= 2'd0;
            wb_valid_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
            wb_src_q   <= 2'd0;
            cnt_q      <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wb_valid_q <= wb_valid_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
            wb_src_q   <= wb_src_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_reg       = wb_reg_q;
    assign wb_data      = wb_data_q;
    assign wb_src       = wb_src_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus pushes expected write-backs, a
// monitor pops and compares them whenever wb_valid is seen.
module tb_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;

    logic                clock;
    logic                reset;
    logic                flush;
    logic [2:0]          req_valid;
    logic [3*REG_W-1:0]  req_reg;
    logic [3*DATA_W-1:0] req_data;
    logic [2:0]          req_ready;
    logic                wb_valid;
    logic [REG_W-1:0]    wb_reg;
    logic [DATA_W-1:0]   wb_data;
    logic [1:0]          wb_src;
    logic [CNT_W-1:0]    conflict_cnt;

    typedef struct {
        logic [REG_W-1:0]  r;
        logic [DATA_W-1:0] d;
        logic [1:0]        s;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int tests  = 0;
    int errors = 0;

    wb_arbiter #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
        .req_ready(req_ready), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .wb_data(wb_data), .wb_src(wb_src), .conflict_cnt(conflict_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; ready is sampled 1ns later.
    task automatic drive(input logic [2:0] v, input logic f,
                         input logic [4:0] r0, input logic [31:0] d0,
                         input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] r2, input logic [31:0] d2);
        @(negedge clock);
        req_valid = v;
        flush     = f;
        req_reg   = {r2, r1, r0};
        req_data  = {d2, d1, d0};
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d, input logic [1:0] s);
        wb_exp_t e;
        e.r = r; e.d = d; e.s = s;
        exp_q.push_back(e);
    endtask

    // Monitor: every registered write-back must match the oldest expectation.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (!reset && wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", {wb_src, wb_reg, wb_data}, 64'h0);
                end else begin
                    wb_exp_t e;
                    e = exp_q.pop_front();
                    chk("wb_reg", 64'(wb_reg), 64'(e.r));
                    chk("wb_data", 64'(wb_data), 64'(e.d));
                    chk("wb_src", 64'(wb_src), 64'(e.s));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = '0; req_reg = '0; req_data = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_wb_valid", 64'(wb_valid), 64'h0);
        chk("rst_wb_reg", 64'(wb_reg), 64'h0);
        chk("rst_wb_data", 64'(wb_data), 64'h0);
        chk("rst_wb_src", 64'(wb_src), 64'h0);
        chk("rst_cnt", 64'(conflict_cnt), 64'h0);

        // Single request from requester 0; pointer moves to 1.
        drive(3'b001, 0, 5'd10, 32'd7, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("single_ready", 64'(req_ready), 64'b001);
        push(5'd10, 32'd7, 2'd0);

        // x0 from requester 1 alongside real from requester 2; pointer -> 0.
        drive(3'b110, 0, 5'd0, 32'd0, 5'd0, 32'hDEAD, 5'd5, 32'd3);
        chk("x0_ready", 64'(req_ready), 64'b110);
        push(5'd5, 32'd3, 2'd2);

        // Full contention from pointer 0; each unit drops after its transfer.
        drive(3'b111, 0, 5'd11, 32'd15, 5'd12, 32'hAA, 5'd13, 32'h55);
        chk("rr0_ready", 64'(req_ready), 64'b001);
        push(5'd11, 32'd15, 2'd0);
        drive(3'b110, 0, 5'd11, 32'd15, 5'd12, 32'hAA, 5'd13, 32'h55);
        chk("rr1_ready", 64'(req_ready), 64'b010);
        push(5'd12, 32'hAA, 2'd1);
        drive(3'b100, 0, 5'd11, 32'd15, 5'd12, 32'hAA, 5'd13, 32'h55);
        chk("rr2_ready", 64'(req_ready), 64'b100);
        push(5'd13, 32'h55, 2'd2);
        drive(3'b000, 0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("rr_cnt", 64'(conflict_cnt), 64'd2);

        // Flush with full contention: no transfer, no count, pointer stays 0.
        drive(3'b111, 1, 5'd9, 32'h11, 5'd8, 32'h22, 5'd7, 32'h33);
        chk("flush_ready", 64'(req_ready), 64'b000);
        drive(3'b111, 0, 5'd9, 32'h11, 5'd8, 32'h22, 5'd7, 32'h33);
        chk("flush_wb_valid", 64'(wb_valid), 64'h0);
        chk("flush_cnt", 64'(conflict_cnt), 64'd2);
        chk("post_flush_ready0", 64'(req_ready), 64'b001);
        push(5'd9, 32'h11, 2'd0);
        drive(3'b110, 0, 5'd9, 32'h11, 5'd8, 32'h22, 5'd7, 32'h33);
        chk("post_flush_ready1", 64'(req_ready), 64'b010);
        push(5'd8, 32'h22, 2'd1);
        drive(3'b100, 0, 5'd9, 32'h11, 5'd8, 32'h22, 5'd7, 32'h33);
        chk("post_flush_ready2", 64'(req_ready), 64'b100);
        push(5'd7, 32'h33, 2'd2);

        // Saturation: counter is 4 here, 20 contended cycles alternate 0/1.
        for (int i = 0; i < 20; i++) begin
            drive(3'b011, 0, 5'd20, 32'(i), 5'd21, 32'(i + 100), 5'd0, 32'd0);
            if (i == 0)  chk("sat_start", 64'(conflict_cnt), 64'd4);
            if (i == 10) chk("sat_14", 64'(conflict_cnt), 64'd14);
            if (i == 11) chk("sat_15", 64'(conflict_cnt), 64'd15);
            if (i % 2 == 0) begin
                chk("sat_ready_even", 64'(req_ready), 64'b001);
                push(5'd20, 32'(i), 2'd0);
            end else begin
                chk("sat_ready_odd", 64'(req_ready), 64'b010);
                push(5'd21, 32'(i + 100), 2'd1);
            end
        end
        drive(3'b000, 0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("sat_final", 64'(conflict_cnt), 64'd15);

        // Async reset while a write-back is registered; pointer is 1 before it.
        drive(3'b001, 0, 5'd3, 32'd4, 5'd0, 32'd0, 5'd0, 32'd0);
        push(5'd3, 32'd4, 2'd0);
        @(posedge clock);
        #3;
        req_valid = '0;
        chk("pre_reset_wb_valid", 64'(wb_valid), 64'h1);
        reset = 1'b1;
        #1;
        chk("async_wb_valid", 64'(wb_valid), 64'h0);
        chk("async_cnt", 64'(conflict_cnt), 64'h0);
        chk("async_wb_data", 64'(wb_data), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        drive(3'b101, 0, 5'd17, 32'hBEEF, 5'd0, 32'd0, 5'd18, 32'hCAFE);
        chk("after_reset_ready", 64'(req_ready), 64'b001);
        push(5'd17, 32'hBEEF, 2'd0);
        drive(3'b100, 0, 5'd17, 32'hBEEF, 5'd0, 32'd0, 5'd18, 32'hCAFE);
        chk("after_reset_ready2", 64'(req_ready), 64'b100);
        push(5'd18, 32'hCAFE, 2'd2);
        drive(3'b000, 0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
